axi4_lite_master_rtl: RTL and testbench
=======================================

# axi4_lite_master_rtl

- Synthesizable AXI4-Lite master: the initiating end of the bus that the AXI4-Lite slave RTL responds to.
- Accepts single read/write commands on a simple valid/ready command port and executes each as one AXI4-Lite transaction.
- Returns the response (and read data) on a response port and flags a sticky timeout when the slave stalls.
- Sits between a local controller and an AXI4-Lite slave; one transaction outstanding at a time.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8.
- ADDRESS_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 256, maximum wait cycles per channel phase before flagging timeout; 0 disables the check.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  transaction address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_resp  out  2  captured bresp/rresp.
- rsp_rdata  out  DATA_WIDTH  captured rdata; 0 for writes.
- err_timeout  out  1  sticky timeout flag.
- AXI4-Lite master ports:
  - awaddr, awvalid (out) / awready (in)
  - wdata, wstrb, wvalid (out) / wready (in)
  - bresp, bvalid (in) / bready (out)
  - araddr, arvalid (out) / arready (in)
  - rdata, rresp, rvalid (in) / rready (out)

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. Accept when cmd_valid && cmd_ready at a rising edge.
  - On accept, register address, data and strobes into the AXI address/data outputs.
  - Write goes to WR_REQ; read goes to RD_REQ.
- WR_REQ: awvalid and wvalid both asserted.
  - Each valid stays high and its payload stays stable until its own handshake.
  - Each valid drops the cycle after its handshake edge. Internal aw_done and w_done flags record completion.
  - When both handshakes have completed, go to WR_RESP. If both occur on the same edge, go to WR_RESP directly.
- WR_RESP: bready=1. On bvalid && bready, capture bresp, deassert bready, set rsp_write=1 and rsp_rdata=0, go to RSP.
- RD_REQ: arvalid=1 until arready is sampled high, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, deassert rready, set rsp_write=0, go to RSP.
- RSP: rsp_valid=1, held with stable contents until rsp_ready is sampled high, then return to IDLE.
- bvalid/rvalid arriving outside WR_RESP/RD_DATA are not acknowledged; the slave holds them until bready/rready.
- Timeout counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Clears on every state transition and on every aw/w handshake.
  - Increments each cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_DATA, saturating.
  - On reaching TIMEOUT_CYCLES, err_timeout is set.
  - The transaction is not aborted; the FSM keeps waiting.
  - err_timeout clears only on reset.
- The counter does not run in RSP; response back-pressure is not an error.

## Timing
- Reset (async assert): every output is 0 (all valids, readies, addresses, wdata, wstrb, rsp_*, err_timeout); state is IDLE.
  - Asserting reset mid-transaction drops the AXI valids immediately; no partial state survives.
  - cmd_ready goes high on the first rising edge after deassertion.
- All outputs are registered except cmd_ready, which decodes the state register.
- Command accepted at edge N: awvalid/wvalid (or arvalid) are high after edge N.
- Write, slave ready at once:
  - aw/w handshake at N+1.
  - bready high after N+1.
  - bvalid sampled at N+2.
  - rsp_valid high after N+2.
  - Minimum accept-to-response latency is 2 cycles.
- Read: arready at N+1, rvalid at N+2, rsp_valid after N+2.
- Throughput: with rsp_ready tied high and a zero-wait slave, the next command is accepted at N+4 (one command per 4 cycles).
- awvalid and wvalid are independent: if wready arrives k cycles after awready, wvalid stays high those extra k cycles while awvalid is already low.

## Test plan
- Write addr 0xABC0_0040, data 0xDEAD_BEEF, strb 0xF, zero-wait slave returning bresp 0 -> awvalid/wvalid each one cycle; rsp_valid 2 cycles after accept with rsp_write=1, rsp_resp=0.
- Slave asserts wready 3 cycles before awready -> wvalid drops after its handshake; awvalid and awaddr stay stable until awready; a single bready phase follows; response correct.
- Read addr 0x0000_0010, slave returns rdata 0xAAAA_AAAA with rresp 2'b10 -> rsp_rdata=0xAAAA_AAAA, rsp_resp=2'b10, rsp_write=0.
- TIMEOUT_CYCLES=8, slave withholds bvalid for 20 cycles -> err_timeout rises 8 cycles into WR_RESP and stays high; the transaction then completes normally.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_* stable throughout; cmd_ready stays 0; next command accepted only after the rsp handshake.
- rst_n asserted while arvalid=1 -> arvalid is 0 immediately; after release, cmd_ready=1 and a new read completes correctly.

Source files
------------

// File: rtl/axi4_lite_master_rtl_if.sv
// AXI4-Lite bus bundle shared by master and slave ends.
// Direction sets are given from each end's point of view.
interface axi4_lite_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master_rtl.sv
// AXI4-Lite master: runs one command per transaction, returns the captured response,
// and raises a sticky timeout flag when any wait phase lasts TIMEOUT_CYCLES cycles.
module axi4_lite_master_rtl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [1:0]               rsp_resp,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     err_timeout,
  axi4_lite_if.master              axi
);
  // state   | meaning
  // IDLE    | waiting for a command     WR_REQ  | aw/w outstanding   WR_RESP | waiting for b
  // RD_REQ  | ar outstanding            RD_DATA | waiting for r      RSP     | response held
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             run_en;
  logic             aw_done;
  logic             w_done;
  logic [CNT_W-1:0] tmo_cnt;
  logic             aw_hs;
  logic             w_hs;
  logic             waiting;

  // run_en keeps cmd_ready low while reset is held and for the release cycle
  assign cmd_ready = run_en && (state == IDLE);
  assign aw_hs     = axi.awvalid && axi.awready;
  assign w_hs      = axi.wvalid && axi.wready;
  assign waiting   = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run_en      <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_resp    <= 2'b00;
      rsp_rdata   <= '0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
    end else begin
      run_en <= 1'b1;
      // transitions and handshakes below override this with a clear
      if (TIMEOUT_CYCLES != 0 && waiting) begin
        if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + CNT_ONE;
        if (tmo_cnt == CNT_MAX - CNT_ONE) err_timeout <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tmo_cnt <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              axi.awaddr  <= cmd_addr;
              axi.wdata   <= cmd_wdata;
              axi.wstrb   <= cmd_wstrb;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR_REQ;
            end else begin
              axi.araddr  <= cmd_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
            tmo_cnt     <= '0;
          end
          if (w_hs) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
            tmo_cnt    <= '0;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            axi.bready <= 1'b1;
            tmo_cnt    <= '0;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            rsp_resp   <= axi.bresp;
            rsp_write  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            tmo_cnt    <= '0;
            state      <= RSP;
          end
        end
        RD_REQ: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            tmo_cnt     <= '0;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            rsp_resp   <= axi.rresp;
            rsp_rdata  <= axi.rdata;
            rsp_write  <= 1'b0;
            rsp_valid  <= 1'b1;
            tmo_cnt    <= '0;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_master_rtl.sv
// Randomized bench for axi4_lite_master_rtl: a behavioural slave with per-phase delays,
// expected responses, latency and timeout derived from the bus timing rules.
module tb_axi4_lite_master_rtl;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic        err_timeout;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic err_exp = 1'b0;

  axi4_lite_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  axi4_lite_master_rtl #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .err_timeout(err_timeout),
    .axi(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called and returns at a falling edge. Delays count cycles before each slave ready/valid.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_d, input int w_d, input int b_d,
                         input int ar_d, input int r_d, input logic [1:0] resp,
                         input logic [31:0] rd, input int hold);
    int t = 0;
    int acc;
    int lat;
    int mx;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    if (wr) begin
      mx = (aw_d > w_d) ? aw_d : w_d;
      fork
        begin
          for (int k = 0; k <= mx + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= aw_d) begin
              check_val("awvalid_hi", bus.awvalid, 1);
              check_val("awaddr", bus.awaddr, addr);
            end else check_val("awvalid_lo", bus.awvalid, 0);
            if (k <= mx) check_val("bready_early", bus.bready, 0);
            bus.awready = (k == aw_d);
          end
        end
        begin
          for (int k = 0; k <= mx + 1; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= w_d) begin
              check_val("wvalid_hi", bus.wvalid, 1);
              check_val("wdata", bus.wdata, data);
              check_val("wstrb", bus.wstrb, strb);
            end else check_val("wvalid_lo", bus.wvalid, 0);
            bus.wready = (k == w_d);
          end
        end
      join
      for (int k = 0; k <= b_d; k++) begin
        check_val("bready_hi", bus.bready, 1);
        check_val("rsp_valid_wait", rsp_valid, 0);
        check_val("err_wr_resp", err_timeout, err_exp || (k >= TOUT));
        if (k == b_d) begin
          bus.bvalid = 1'b1;
          bus.bresp  = resp;
        end
        @(negedge clk);
      end
      bus.bvalid = 1'b0;
      bus.bresp  = 2'($urandom);
      if (b_d >= TOUT) err_exp = 1'b1;
      check_val("bready_lo", bus.bready, 0);
      lat = 2 + mx + b_d;
    end else begin
      for (int k = 0; k <= ar_d; k++) begin
        check_val("arvalid_hi", bus.arvalid, 1);
        check_val("araddr", bus.araddr, addr);
        check_val("awvalid_rd", bus.awvalid, 0);
        bus.arready = (k == ar_d);
        @(negedge clk);
      end
      bus.arready = 1'b0;
      check_val("arvalid_lo", bus.arvalid, 0);
      for (int k = 0; k <= r_d; k++) begin
        check_val("rready_hi", bus.rready, 1);
        check_val("rsp_valid_wait", rsp_valid, 0);
        check_val("err_rd_data", err_timeout, err_exp || (k >= TOUT));
        if (k == r_d) begin
          bus.rvalid = 1'b1;
          bus.rdata  = rd;
          bus.rresp  = resp;
        end
        @(negedge clk);
      end
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      bus.rresp  = 2'($urandom);
      if (r_d >= TOUT) err_exp = 1'b1;
      check_val("rready_lo", bus.rready, 0);
      lat = 2 + ar_d + r_d;
    end
    check_val("latency", cyc - acc, lat);
    for (int k = 0; k <= hold; k++) begin
      check_val("rsp_valid", rsp_valid, 1);
      check_val("rsp_write", rsp_write, wr);
      check_val("rsp_resp", rsp_resp, resp);
      check_val("rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
      check_val("cmd_ready_busy", cmd_ready, 0);
      check_val("err_rsp", err_timeout, err_exp);
      rsp_ready = (k == hold);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check_val("rsp_valid_lo", rsp_valid, 0);
    check_val("cmd_ready_next", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    #12;
    check_val("rst_cmd_ready", cmd_ready, 0);
    check_val("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check_val("rst_addr", {bus.awaddr, bus.araddr}, 0);
    check_val("rst_wdata", {bus.wdata, bus.wstrb}, 0);
    check_val("rst_rsp", {rsp_valid, rsp_write, rsp_resp}, 0);
    check_val("rst_rdata", rsp_rdata, 0);
    check_val("rst_err", err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("cmd_ready_release", cmd_ready, 0);
    @(negedge clk);
    check_val("cmd_ready_after_rst", cmd_ready, 1);

    run_txn(1'b1, 32'hABC0_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1'b1, 32'h0000_1234, 32'h1357_9BDF, 4'h5, 3, 0, 0, 0, 0, 2'b01, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'hAAAA_AAAA, 0);
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 1, 2, 2'b00, 32'h5555_0001, 5);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), 2'($urandom),
              $urandom, $urandom_range(0, 3));
    end

    run_txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 0, 0, 20, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b11, 32'h0BAD_CAFE, 1);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0200;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("arvalid_pre_rst", bus.arvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arvalid_async_rst", bus.arvalid, 0);
    check_val("cmd_ready_in_rst", cmd_ready, 0);
    check_val("err_cleared", err_timeout, 0);
    err_exp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("cmd_ready_rerun", cmd_ready, 1);
    run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
